camera_controller: RTL and testbench
====================================

CAMERA_CONTROLLER -- requirements
Module: camera_controller

Interface
REQ-001 SHALL have parameter FP_WIDTH, default 32: width of signed fixed-point position words (Q16.16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted.
REQ-003 SHALL have parameter STEP, default 32'h0000_0400: base per-frame move step (1/64), in the same fixed-point format.
REQ-004 SHALL have parameter LIMIT, default 32'h0004_0000: saturation magnitude (4.0) for every position axis.
REQ-005 SHALL have port clk_in, input, 1: system clock; all logic is single-clock.
REQ-006 SHALL have port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports btnl, btnr, btnu, btnd, input, 1 each: raw, asynchronous push-buttons.
REQ-008 SHALL have port sw, input, 16: sw[0] axis mode, sw[3:1] speed shift, sw[4] freeze, sw[15:14] fractal select; all other bits unused.
REQ-009 SHALL have port new_frame_in, input, 1: one-cycle pulse from the ray marcher marking a frame boundary.
REQ-010 SHALL have ports pos_x_out, pos_y_out, pos_z_out, output, FP_WIDTH each, signed: camera position fed to the ray marcher.
REQ-011 SHALL have port fractal_sel_out, output, 2: fractal select fed to the ray marcher.
REQ-012 SHALL have port updated_out, output, 1: one-cycle pulse when new committed values appear.

Function
REQ-013 SHALL pass each button and sw through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each button independently: per-button counter resets on any change of the synchronized level; the accepted level updates only once the counter reaches DEBOUNCE_CYCLES-1 with the level unchanged.
REQ-015 SHALL compute step = STEP << sw[3:1] (shift 0..7), with no wrap of the step value.
REQ-016 SHALL, with sw[0]=0, map btnr/btnl to +x/-x and btnu/btnd to +y/-y; with sw[0]=1, map btnu/btnd to +z/-z and btnl/btnr have no effect.
REQ-017 SHALL treat both buttons of an opposing pair held together as no motion on that axis.
REQ-018 SHALL run a two-state FSM: WAIT (idle until new_frame_in=1) and COMMIT (exactly one cycle, then returns to WAIT).
REQ-019 SHALL, in COMMIT, update each position register to old +/- step based on the accepted button levels sampled in the cycle new_frame_in was high, and latch fractal_sel_out from synchronized sw[15:14].
REQ-020 SHALL compute each addition at FP_WIDTH+1 bits and saturate the result to [-LIMIT, +LIMIT].
REQ-021 SHALL hold all positions unchanged in COMMIT when sw[4]=1; fractal_sel_out still latches.
REQ-022 SHALL hold outputs constant between commits, so one frame always renders with a single camera state.
REQ-023 SHALL make new values visible on the clock edge ending COMMIT, and assert updated_out high for that cycle only; latency from new_frame_in is 2 cycles.
REQ-024 SHALL ignore a new_frame_in pulse that arrives while in COMMIT, with no queuing.

Reset
REQ-025 SHALL, while rst_n_in=0, immediately force pos_x_out=0, pos_y_out=0, pos_z_out=32'hFFFE_8000 (-1.5), fractal_sel_out=0, updated_out=0, the FSM to WAIT, all debounce counters to 0, and all accepted button levels to 0.
REQ-026 SHALL, when reset is asserted mid-COMMIT, discard the partial commit with no glitch pulse on updated_out after release.
REQ-027 SHALL ignore new_frame_in during the first cycle after reset release.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 SHALL be checked for reset: rst_n_in low -> pos=(0,0,-1.5), fractal_sel_out=0, updated_out=0; then new_frame_in with no buttons -> positions unchanged and updated_out pulses once, 2 cycles after new_frame_in.
REQ-029 SHALL be checked for debounce: btnr held 3 cycles then released, then new_frame_in -> pos_x_out stays 0; btnr held 10 cycles, sw=0, then new_frame_in -> pos_x_out=32'h0000_0400.
REQ-030 SHALL be checked for speed and mode: sw[0]=1, sw[3:1]=3, btnu held, 2 frames -> pos_z_out = -1.5 + 2*0x2000 = 32'hFFFE_C000.
REQ-031 SHALL be checked for saturation: sw[3:1]=7, btnl held for 20 frames -> pos_x_out = 32'hFFFC_0000, never beyond this value.
REQ-032 SHALL be checked for opposing and freeze: btnl+btnr held -> x unchanged; sw[4]=1 with btnd held -> y unchanged, but sw[15:14]=2'b10 still gives fractal_sel_out=2 after commit.
REQ-033 SHALL be checked for reset mid-operation and back-to-back frames: rst_n_in pulsed low during COMMIT -> reset values, no updated_out pulse; new_frame_in on two consecutive cycles -> exactly one commit.

Source files
------------

// File: rtl/camera_controller.sv
// Camera position controller for the ray marcher.
// Synchronizes and debounces four push-buttons plus the switch bank, and on
// each frame boundary commits one saturated fixed-point step per axis.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   btnl/r/u/d      raw push-buttons
//   sw[15:0]        [0] axis mode, [3:1] speed shift, [4] freeze, [15:14] fractal
//   new_frame_in    one-cycle frame boundary pulse
//   pos_*_out       signed Q16.16 camera position
//   fractal_sel_out fractal select
//   updated_out     one-cycle pulse when committed values change
module camera_controller #(
    parameter int                  FP_WIDTH        = 32,
    parameter int                  DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [FP_WIDTH-1:0] STEP            = FP_WIDTH'(32'h0000_0400),
    parameter logic [FP_WIDTH-1:0] LIMIT           = FP_WIDTH'(32'h0004_0000)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       btnl,
    input  logic                       btnr,
    input  logic                       btnu,
    input  logic                       btnd,
    input  logic [15:0]                sw,
    input  logic                       new_frame_in,
    output logic signed [FP_WIDTH-1:0] pos_x_out,
    output logic signed [FP_WIDTH-1:0] pos_y_out,
    output logic signed [FP_WIDTH-1:0] pos_z_out,
    output logic [1:0]                 fractal_sel_out,
    output logic                       updated_out
);

    localparam int                    CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]         CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam int                    SW_W     = FP_WIDTH + 8;
    localparam logic [SW_W-1:0]       STEP_CAP = SW_W'(LIMIT) << 1;
    localparam logic signed [FP_WIDTH:0] LIM_POS = $signed({1'b0, LIMIT});
    localparam logic signed [FP_WIDTH:0] LIM_NEG = -LIM_POS;
    localparam logic [FP_WIDTH-1:0]   Z_RESET  = -(FP_WIDTH'(32'h0001_8000));

    typedef enum logic {S_WAIT, S_COMMIT} state_t;
    state_t state, state_next;

    // Button vectors are ordered {l, r, u, d}.
    logic [3:0]    btn_meta, btn_sync, btn_prev, btn_acc;
    logic [CW-1:0] db_cnt [4];
    logic [15:0]   sw_meta, sw_sync;
    logic          armed;
    logic          capture, commit;
    logic [5:0]    mv_now, mv;    // {x+, x-, y+, y-, z+, z-}
    logic [SW_W-1:0]   step_wide;
    logic [FP_WIDTH:0] step;
    logic          sw_unused;

    assign sw_unused = ^sw_sync[13:5];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= {btnl, btnr, btnu, btnd};
            btn_sync <= btn_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // Counter restarts whenever the synchronized level moves; once it has
    // sat at CNT_MAX the accepted level simply tracks the stable input.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_prev <= '0;
            btn_acc  <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_prev <= btn_sync;
            for (int unsigned i = 0; i < 4; i++) begin
                if (btn_sync[i] != btn_prev[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    btn_acc[i] <= btn_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Opposing buttons cancel; mode selects x/y versus z for the pairs.
    always_comb begin
        mv_now = '0;
        if (!sw_sync[0]) begin
            mv_now[5] = btn_acc[2] & ~btn_acc[3];
            mv_now[4] = btn_acc[3] & ~btn_acc[2];
            mv_now[3] = btn_acc[1] & ~btn_acc[0];
            mv_now[2] = btn_acc[0] & ~btn_acc[1];
        end else begin
            mv_now[1] = btn_acc[1] & ~btn_acc[0];
            mv_now[0] = btn_acc[0] & ~btn_acc[1];
        end
    end

    // Shift in a wide word so no bits are lost, then cap at 2*LIMIT; any
    // larger step saturates identically and this keeps it in FP_WIDTH+1 bits.
    assign step_wide = SW_W'(STEP) << sw_sync[3:1];
    assign step      = (step_wide > STEP_CAP) ? STEP_CAP[FP_WIDTH:0]
                                              : step_wide[FP_WIDTH:0];

    function automatic logic [FP_WIDTH-1:0] move(
        input logic [FP_WIDTH-1:0] old,
        input logic                up,
        input logic                down,
        input logic [FP_WIDTH:0]   stp
    );
        logic signed [FP_WIDTH:0] sum;
        sum = $signed({old[FP_WIDTH-1], old});
        if (up)        sum = sum + $signed(stp);
        else if (down) sum = sum - $signed(stp);
        if (sum > LIM_POS)      sum = LIM_POS;
        else if (sum < LIM_NEG) sum = LIM_NEG;
        return sum[FP_WIDTH-1:0];
    endfunction

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            S_WAIT: begin
                if (new_frame_in && armed) begin
                    capture    = 1'b1;
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit     = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_WAIT;
            armed <= 1'b0;
            mv    <= '0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (capture) mv <= mv_now;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pos_x_out       <= '0;
            pos_y_out       <= '0;
            pos_z_out       <= Z_RESET;
            fractal_sel_out <= '0;
            updated_out     <= 1'b0;
        end else begin
            updated_out <= commit;
            if (commit) begin
                fractal_sel_out <= sw_sync[15:14];
                if (!sw_sync[4]) begin
                    pos_x_out <= move(pos_x_out, mv[5], mv[4], step);
                    pos_y_out <= move(pos_y_out, mv[3], mv[2], step);
                    pos_z_out <= move(pos_z_out, mv[1], mv[0], step);
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_controller.sv
// Directed self-checking bench for camera_controller (DEBOUNCE_CYCLES=4).
module tb_camera_controller;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic [15:0] sw = '0;
    logic        new_frame_in = 1'b0;
    logic signed [31:0] pos_x_out, pos_y_out, pos_z_out;
    logic [1:0]  fractal_sel_out;
    logic        updated_out;

    int nvec = 0;
    int nerr = 0;
    int pulses;

    always #5 clk_in = ~clk_in;

    camera_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .btnl            (btnl),
        .btnr            (btnr),
        .btnu            (btnu),
        .btnd            (btnd),
        .sw              (sw),
        .new_frame_in    (new_frame_in),
        .pos_x_out       (pos_x_out),
        .pos_y_out       (pos_y_out),
        .pos_z_out       (pos_z_out),
        .fractal_sel_out (fractal_sel_out),
        .updated_out     (updated_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse new_frame_in for one cycle and return once the commit is visible
    // and updated_out has dropped again.
    task automatic frame();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values, applied asynchronously.
        #3 rst_n_in = 1'b0;
        #2;
        check("rst_x", pos_x_out, 32'h0000_0000);
        check("rst_y", pos_y_out, 32'h0000_0000);
        check("rst_z", pos_z_out, 32'hFFFE_8000);
        check("rst_frac", 32'(fractal_sel_out), 32'd0);
        check("rst_upd", 32'(updated_out), 32'd0);
        wait_cycles(3);
        rst_n_in = 1'b1;
        wait_cycles(3);

        // Frame with no buttons: 2-cycle latency, single pulse.
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        check("upd_lat1", 32'(updated_out), 32'd0);
        tick();
        check("upd_lat2", 32'(updated_out), 32'd1);
        check("idle_x", pos_x_out, 32'h0000_0000);
        check("idle_y", pos_y_out, 32'h0000_0000);
        check("idle_z", pos_z_out, 32'hFFFE_8000);
        tick();
        check("upd_drop", 32'(updated_out), 32'd0);

        // Short press is rejected by the debouncer.
        btnr = 1'b1;
        wait_cycles(3);
        btnr = 1'b0;
        wait_cycles(10);
        frame();
        check("db_short_x", pos_x_out, 32'h0000_0000);

        // Long press is accepted: one base step on +x.
        btnr = 1'b1;
        wait_cycles(10);
        frame();
        btnr = 1'b0;
        check("db_long_x", pos_x_out, 32'h0000_0400);
        wait_cycles(10);

        // z mode, shift 3 (step 0x2000), two frames.
        sw = 16'h0007;
        btnu = 1'b1;
        wait_cycles(10);
        frame();
        frame();
        btnu = 1'b0;
        check("mode_z", pos_z_out, 32'hFFFE_C000);
        check("mode_y", pos_y_out, 32'h0000_0000);
        check("mode_x", pos_x_out, 32'h0000_0400);
        wait_cycles(10);

        // Shift 7 (step 2.0) on -x, saturating at -4.0.
        sw = 16'h000E;
        btnl = 1'b1;
        wait_cycles(10);
        frame();
        check("sat_first", pos_x_out, 32'hFFFE_0400);
        for (int i = 1; i < 20; i++) begin
            frame();
            check("sat_floor", 32'(pos_x_out < -32'sh0004_0000), 32'd0);
        end
        check("sat_final", pos_x_out, 32'hFFFC_0000);
        btnl = 1'b0;
        wait_cycles(10);

        // Opposing buttons cancel.
        sw = 16'h0000;
        btnl = 1'b1;
        btnr = 1'b1;
        wait_cycles(10);
        frame();
        check("opp_x", pos_x_out, 32'hFFFC_0000);
        btnl = 1'b0;
        btnr = 1'b0;
        wait_cycles(10);

        // Freeze holds positions but fractal select still latches.
        sw = 16'h8010;
        btnd = 1'b1;
        wait_cycles(10);
        frame();
        check("frz_y", pos_y_out, 32'h0000_0000);
        check("frz_frac", 32'(fractal_sel_out), 32'd2);
        btnd = 1'b0;
        sw = 16'h0000;
        wait_cycles(10);

        // Back-to-back new_frame_in: second pulse lands in COMMIT and is dropped.
        btnu = 1'b1;
        wait_cycles(10);
        pulses = 0;
        new_frame_in = 1'b1;
        tick();
        pulses += int'(updated_out);
        tick();
        pulses += int'(updated_out);
        new_frame_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(updated_out);
        end
        btnu = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd1);
        check("b2b_y", pos_y_out, 32'h0000_0400);
        check("b2b_frac", 32'(fractal_sel_out), 32'd0);
        wait_cycles(10);

        // Reset during COMMIT, then a frame pulse in the first cycle after release.
        btnr = 1'b1;
        wait_cycles(10);
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        #2 rst_n_in = 1'b0;
        #1;
        check("mid_rst_x", pos_x_out, 32'h0000_0000);
        check("mid_rst_y", pos_y_out, 32'h0000_0000);
        check("mid_rst_z", pos_z_out, 32'hFFFE_8000);
        check("mid_rst_upd", 32'(updated_out), 32'd0);
        @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        new_frame_in = 1'b1;
        pulses = 0;
        tick();
        new_frame_in = 1'b0;
        pulses += int'(updated_out);
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(updated_out);
        end
        btnr = 1'b0;
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_x", pos_x_out, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
